// File: rtl/frame_sync_display_buffer.sv
// Shadow/active display-state bank: the game side fills and commits the shadow,
// and the active outputs are reloaded only on a VGA frame-start pulse.
module frame_sync_display_buffer #(
    parameter int NUM_OBS    = 10,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int MODE_W     = 2,
    parameter int RST_X      = 700,
    parameter int RST_Y      = 500,
    parameter int RST_PLAYER = 240,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = $clog2(NUM_OBS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [X_W-1:0]           wr_x_left,
    input  logic [X_W-1:0]           wr_x_right,
    input  logic [Y_W-1:0]           wr_y_up,
    input  logic [Y_W-1:0]           wr_y_down,
    input  logic                     hdr_en,
    input  logic [Y_W-1:0]           wr_player_y,
    input  logic [MODE_W-1:0]        wr_gamemode,
    input  logic                     commit,
    input  logic                     frame_start,
    output logic                     wr_ready,
    output logic                     pending,
    output logic [NUM_OBS*X_W-1:0]   obstacle_x_left,
    output logic [NUM_OBS*X_W-1:0]   obstacle_x_right,
    output logic [NUM_OBS*Y_W-1:0]   obstacle_y_up,
    output logic [NUM_OBS*Y_W-1:0]   obstacle_y_down,
    output logic [Y_W-1:0]           player_y,
    output logic [MODE_W-1:0]        gamemode,
    output logic                     swap_done,
    output logic [CNT_W-1:0]         repeat_cnt,
    output logic [CNT_W-1:0]         overrun_cnt
);

    localparam logic [X_W-1:0]   RST_X_L   = RST_X[X_W-1:0];
    localparam logic [Y_W-1:0]   RST_Y_L   = RST_Y[Y_W-1:0];
    localparam logic [Y_W-1:0]   RST_P_L   = RST_PLAYER[Y_W-1:0];
    localparam logic [IDX_W:0]   NUM_OBS_L = NUM_OBS[IDX_W:0];
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [X_W-1:0]    sh_xl [NUM_OBS];
    logic [X_W-1:0]    sh_xr [NUM_OBS];
    logic [Y_W-1:0]    sh_yu [NUM_OBS];
    logic [Y_W-1:0]    sh_yd [NUM_OBS];
    logic [Y_W-1:0]    sh_py;
    logic [MODE_W-1:0] sh_gm;

    logic idx_ok;
    logic wr_hit;
    logic hdr_hit;
    logic do_swap;
    logic do_repeat;
    logic do_overrun;

    assign idx_ok   = ({1'b0, wr_idx} < NUM_OBS_L);
    assign pending  = (state_q == LOCKED);
    assign wr_ready = (state_q == OPEN);

    always_comb begin
        state_d    = state_q;
        wr_hit     = 1'b0;
        hdr_hit    = 1'b0;
        do_swap    = 1'b0;
        do_repeat  = 1'b0;
        do_overrun = 1'b0;
        unique case (state_q)
            OPEN: begin
                wr_hit    = wr_en && idx_ok;
                hdr_hit   = hdr_en;
                do_repeat = frame_start;
                if (commit) state_d = LOCKED;
            end
            LOCKED: begin
                // a write and a commit in one cycle count as one overrun
                do_overrun = wr_en || hdr_en || commit;
                if (frame_start) begin
                    do_swap = 1'b1;
                    state_d = OPEN;
                end
            end
            default: state_d = OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= OPEN;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                sh_xl[i] <= RST_X_L;
                sh_xr[i] <= RST_X_L;
                sh_yu[i] <= RST_Y_L;
                sh_yd[i] <= RST_Y_L;
            end
            sh_py <= RST_P_L;
            sh_gm <= '0;
        end else begin
            if (wr_hit) begin
                sh_xl[wr_idx] <= wr_x_left;
                sh_xr[wr_idx] <= wr_x_right;
                sh_yu[wr_idx] <= wr_y_up;
                sh_yd[wr_idx] <= wr_y_down;
            end
            if (hdr_hit) begin
                sh_py <= wr_player_y;
                sh_gm <= wr_gamemode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                obstacle_x_left[i*X_W +: X_W]  <= RST_X_L;
                obstacle_x_right[i*X_W +: X_W] <= RST_X_L;
                obstacle_y_up[i*Y_W +: Y_W]    <= RST_Y_L;
                obstacle_y_down[i*Y_W +: Y_W]  <= RST_Y_L;
            end
            player_y  <= RST_P_L;
            gamemode  <= '0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= do_swap;
            if (do_swap) begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    obstacle_x_left[i*X_W +: X_W]  <= sh_xl[i];
                    obstacle_x_right[i*X_W +: X_W] <= sh_xr[i];
                    obstacle_y_up[i*Y_W +: Y_W]    <= sh_yu[i];
                    obstacle_y_down[i*Y_W +: Y_W]  <= sh_yd[i];
                end
                player_y <= sh_py;
                gamemode <= sh_gm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_cnt  <= '0;
            overrun_cnt <= '0;
        end else begin
            if (do_repeat && repeat_cnt != CNT_MAX)
                repeat_cnt <= repeat_cnt + 1'b1;
            if (do_overrun && overrun_cnt != CNT_MAX)
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_sync_display_buffer.sv
// Bench for frame_sync_display_buffer: directed scenarios plus random traffic
// compared every cycle against a bank-level reference model.
module tb_frame_sync_display_buffer;

    localparam int N  = 10;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int MW = 2;
    localparam int IW = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst, wr_en, hdr_en, commit, frame_start;
    logic [IW-1:0] wr_idx;
    logic [XW-1:0] wr_x_left, wr_x_right;
    logic [YW-1:0] wr_y_up, wr_y_down, wr_player_y;
    logic [MW-1:0] wr_gamemode;
    logic wr_ready, pending, swap_done;
    logic [N*XW-1:0] obstacle_x_left, obstacle_x_right;
    logic [N*YW-1:0] obstacle_y_up, obstacle_y_down;
    logic [YW-1:0] player_y;
    logic [MW-1:0] gamemode;
    logic [CW-1:0] repeat_cnt, overrun_cnt;

    always #5 clk = ~clk;

    frame_sync_display_buffer dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x_left(wr_x_left), .wr_x_right(wr_x_right),
        .wr_y_up(wr_y_up), .wr_y_down(wr_y_down),
        .hdr_en(hdr_en), .wr_player_y(wr_player_y),
        .wr_gamemode(wr_gamemode),
        .commit(commit), .frame_start(frame_start),
        .wr_ready(wr_ready), .pending(pending),
        .obstacle_x_left(obstacle_x_left),
        .obstacle_x_right(obstacle_x_right),
        .obstacle_y_up(obstacle_y_up),
        .obstacle_y_down(obstacle_y_down),
        .player_y(player_y), .gamemode(gamemode),
        .swap_done(swap_done),
        .repeat_cnt(repeat_cnt), .overrun_cnt(overrun_cnt)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // reference model: shadow as plain arrays, active as the packed picture
    int m_sxl [N];
    int m_sxr [N];
    int m_syu [N];
    int m_syd [N];
    int m_spy, m_sgm;
    logic [N*XW-1:0] m_xl, m_xr;
    logic [N*YW-1:0] m_yu, m_yd;
    int m_py, m_gm, m_rep, m_ovr;
    bit m_pend, m_swap;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int sat(int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_sxl[i] = 700; m_sxr[i] = 700;
            m_syu[i] = 500; m_syd[i] = 500;
            m_xl[i*XW +: XW] = 10'd700; m_xr[i*XW +: XW] = 10'd700;
            m_yu[i*YW +: YW] = 9'd500;  m_yd[i*YW +: YW] = 9'd500;
        end
        m_spy = 240; m_sgm = 0; m_py = 240; m_gm = 0;
        m_rep = 0; m_ovr = 0; m_pend = 0; m_swap = 0;
    endfunction

    function automatic void model_step();
        m_swap = 0;
        if (rst) begin
            model_reset();
        end else if (!m_pend) begin
            if (wr_en && int'(wr_idx) < N) begin
                m_sxl[wr_idx] = wr_x_left;  m_sxr[wr_idx] = wr_x_right;
                m_syu[wr_idx] = wr_y_up;    m_syd[wr_idx] = wr_y_down;
            end
            if (hdr_en) begin
                m_spy = wr_player_y; m_sgm = wr_gamemode;
            end
            if (frame_start) m_rep = sat(m_rep);
            if (commit) m_pend = 1;
        end else begin
            if (wr_en || hdr_en || commit) m_ovr = sat(m_ovr);
            if (frame_start) begin
                for (int i = 0; i < N; i++) begin
                    m_xl[i*XW +: XW] = XW'(m_sxl[i]);
                    m_xr[i*XW +: XW] = XW'(m_sxr[i]);
                    m_yu[i*YW +: YW] = YW'(m_syu[i]);
                    m_yd[i*YW +: YW] = YW'(m_syd[i]);
                end
                m_py = m_spy; m_gm = m_sgm;
                m_pend = 0; m_swap = 1;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("x_left", obstacle_x_left, m_xl);
            chk("x_right", obstacle_x_right, m_xr);
            chk("y_up", obstacle_y_up, m_yu);
            chk("y_down", obstacle_y_down, m_yd);
            chk("player_y", player_y, m_py);
            chk("gamemode", gamemode, m_gm);
            chk("pending", pending, m_pend);
            chk("wr_ready", wr_ready, !m_pend);
            chk("swap_done", swap_done, m_swap);
            chk("repeat_cnt", repeat_cnt, m_rep);
            chk("overrun_cnt", overrun_cnt, m_ovr);
        end
    end

    task automatic clr();
        rst = 0; wr_en = 0; hdr_en = 0; commit = 0; frame_start = 0;
        wr_idx = '0; wr_x_left = '0; wr_x_right = '0;
        wr_y_up = '0; wr_y_down = '0; wr_player_y = '0; wr_gamemode = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        clr();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(int idx, int xl, int xr, int yu, int yd);
        wr_en = 1; wr_idx = IW'(idx);
        wr_x_left = XW'(xl); wr_x_right = XW'(xr);
        wr_y_up = YW'(yu); wr_y_down = YW'(yd);
    endtask

    logic [N*XW-1:0] all700;
    logic [N*XW-1:0] snap_xl;

    initial begin
        for (int i = 0; i < N; i++) all700[i*XW +: XW] = 10'd700;
        clr();
        model_reset();
        @(negedge clk);
        rst = 1;
        tick();
        chk_en = 1;
        rst = 1;
        tick();
        ticks(3);
        chk("lit_rst_xl", obstacle_x_left, all700);
        chk("lit_rst_py", player_y, 240);
        chk("lit_rst_gm", gamemode, 0);
        chk("lit_rst_rdy", wr_ready, 1);
        chk("lit_rst_rep", repeat_cnt, 0);
        chk("lit_rst_yu0", obstacle_y_up[YW-1:0], 500);

        wr(3, 100, 140, 50, 200); tick();
        hdr_en = 1; wr_player_y = 120; wr_gamemode = 1; tick();
        commit = 1; tick();
        ticks(4);
        frame_start = 1;
        chk("lit_pre_xl3", obstacle_x_left[3*XW +: XW], 700);
        tick();
        chk("lit_xl3", obstacle_x_left[3*XW +: XW], 100);
        chk("lit_yd3", obstacle_y_down[3*YW +: YW], 200);
        chk("lit_xl2", obstacle_x_left[2*XW +: XW], 700);
        chk("lit_py", player_y, 120);
        chk("lit_swap", swap_done, 1);
        chk("lit_pend0", pending, 0);
        tick();
        chk("lit_swap_off", swap_done, 0);

        commit = 1; tick();
        wr(3, 300, 140, 50, 200); tick();
        commit = 1; tick();
        chk("lit_rdy_locked", wr_ready, 0);
        chk("lit_ovr2", overrun_cnt, 2);
        frame_start = 1; tick();
        chk("lit_xl3_kept", obstacle_x_left[3*XW +: XW], 100);

        snap_xl = obstacle_x_left;
        for (int i = 0; i < 3; i++) begin
            frame_start = 1; tick();
            chk("lit_rep_noswap", swap_done, 0);
        end
        chk("lit_rep3", repeat_cnt, 3);
        chk("lit_rep_bank", obstacle_x_left, snap_xl);
        for (int i = 0; i < 300; i++) begin
            frame_start = 1; tick();
        end
        chk("lit_rep_sat", repeat_cnt, 255);

        commit = 1; frame_start = 1; tick();
        chk("lit_cf_pend", pending, 1);
        chk("lit_cf_swap", swap_done, 0);
        frame_start = 1; tick();
        chk("lit_cf_swap2", swap_done, 1);

        snap_xl = obstacle_x_left;
        wr(12, 1, 2, 3, 4); tick();
        commit = 1; tick();
        frame_start = 1; tick();
        chk("lit_oob_bank", obstacle_x_left, snap_xl);

        wr(5, 11, 22, 33, 44); tick();
        commit = 1; tick();
        rst = 1; tick();
        chk("lit_rst_pend", pending, 0);
        chk("lit_rst_xl5", obstacle_x_left, all700);
        frame_start = 1; tick();
        chk("lit_rst_rep1", repeat_cnt, 1);
        chk("lit_rst_noswap", swap_done, 0);
        chk("lit_rst_xl_after", obstacle_x_left, all700);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1)
                wr($urandom_range(0, 15), $urandom, $urandom, $urandom, $urandom);
            hdr_en = ($urandom_range(0, 3) == 0);
            wr_player_y = YW'($urandom);
            wr_gamemode = MW'($urandom);
            commit = ($urandom_range(0, 7) == 0);
            frame_start = ($urandom_range(0, 9) == 0);
            tick();
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sync_display_buffer.md
Name: frame_sync_display_buffer

Overview:
- Parametrised shadow/active register bank that carries game-logic display state (obstacles, player position, game mode) to the pixel generator.
- The game side fills the shadow bank and commits it. The bank is copied to the active outputs only on a frame-start pulse from the VGA timing path, so the picture never shows a half-updated frame.
- Sits between game_logic/map and vga_screen_pic. Supports NUM_OBS obstacle channels, with frame-repeat and overrun statistics.

Parameters:
- NUM_OBS, 10, number of obstacle channels.
- X_W, 10, width of obstacle_x_left / obstacle_x_right fields.
- Y_W, 9, width of obstacle_y_up / obstacle_y_down / player_y fields.
- MODE_W, 2, gamemode width.
- RST_X, 700, reset value of every X field (off-screen).
- RST_Y, 500, reset value of every obstacle Y field (off-screen).
- RST_PLAYER, 240, reset value of player_y.
- CNT_W, 8, width of the statistics counters.
- IDX_W, $clog2(NUM_OBS), width of the index (derived).

Ports:
- clk  in  1  single design clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write one obstacle entry into the shadow bank
- wr_idx  in  IDX_W  obstacle index to write
- wr_x_left  in  X_W  shadow data
- wr_x_right  in  X_W  shadow data
- wr_y_up  in  Y_W  shadow data
- wr_y_down  in  Y_W  shadow data
- hdr_en  in  1  write player/mode header into the shadow bank
- wr_player_y  in  Y_W  shadow header data
- wr_gamemode  in  MODE_W  shadow header data
- commit  in  1  one-cycle pulse: shadow bank complete
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- wr_ready  out  1  shadow bank accepts writes (= !pending)
- pending  out  1  committed shadow waiting for frame_start
- obstacle_x_left  out  NUM_OBS*X_W  active bank, packed, index 0 in LSBs
- obstacle_x_right  out  NUM_OBS*X_W  active bank, packed as above
- obstacle_y_up  out  NUM_OBS*Y_W  active bank, packed as above
- obstacle_y_down  out  NUM_OBS*Y_W  active bank, packed as above
- player_y  out  Y_W  active header
- gamemode  out  MODE_W  active header
- swap_done  out  1  one-cycle pulse: active bank just updated
- repeat_cnt  out  CNT_W  frame_starts with no pending commit (saturating)
- overrun_cnt  out  CNT_W  rejected commits/writes while pending (saturating)

Behaviour:
- Reset: all shadow and active X fields = RST_X; all Y fields = RST_Y; player_y = RST_PLAYER; gamemode = 0. pending = 0, wr_ready = 1, swap_done = 0, both counters = 0. Reset mid-operation discards any pending commit.
- States:
  - OPEN (pending = 0): writes accepted.
  - LOCKED (pending = 1): shadow frozen.
- OPEN:
  - wr_en with wr_idx < NUM_OBS updates that shadow entry at the clock edge.
  - wr_en with wr_idx >= NUM_OBS is dropped silently; no state change.
  - hdr_en updates the shadow header.
  - wr_en, hdr_en and commit may all be asserted in the same cycle. Writes land, then the state moves to LOCKED.
  - commit -> LOCKED at the next edge.
- LOCKED:
  - wr_en/hdr_en dropped; overrun_cnt +1 per cycle in which either is asserted.
  - commit ignored; overrun_cnt +1.
  - A write and a commit in the same cycle count once.
- frame_start while LOCKED (cycle N):
  - All active fields <= shadow fields, in parallel, in one cycle.
  - pending <= 0.
  - Edge N+1: new active values visible and swap_done = 1 for exactly one cycle.
  - Shadow keeps its contents after the copy (incremental updates allowed).
- frame_start while OPEN: no copy, active bank unchanged, repeat_cnt +1.
- frame_start and commit in the same cycle while OPEN: commit takes effect (LOCKED). No swap that cycle; repeat_cnt +1; the swap occurs at the next frame_start.
- Counters saturate at 2^CNT_W-1; they do not wrap. Cleared only by rst.
- Active outputs are driven directly from registers; no combinational path from any input.

Test Plan:
- Reset, then 3 idle cycles -> all obstacle_x = 700, obstacle_y = 500, player_y = 240, gamemode = 0, wr_ready = 1, counters = 0.
- Write idx 3 {x_left = 100, x_right = 140, y_up = 50, y_down = 200}, hdr {player_y = 120, mode = 1}, commit, frame_start 5 cycles later -> outputs unchanged until the edge after frame_start. Then idx 3 fields and header match the written values, other indices stay at reset values, swap_done is a single 1-cycle pulse, pending = 0.
- After commit, wr_en idx 3 x_left = 300, then a second commit -> wr_ready = 0, overrun_cnt = 2, and after frame_start idx 3 x_left = 100 (not 300).
- Three frame_start pulses with no commit -> active bank unchanged, no swap_done, repeat_cnt = 3. Then 300 more pulses -> repeat_cnt = 255.
- commit and frame_start in the same cycle -> no swap, repeat_cnt +1, pending = 1. Swap happens at the next frame_start.
- wr_en with wr_idx = 12 (NUM_OBS = 10) -> no change to any entry. Separately, rst asserted while pending -> pending = 0, all fields back to reset values, the following frame_start counts as a repeat.
